// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register dump engine.
// The Check state exists only when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } dump_state_e;

  function automatic int get_min_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_dump.sv
// Streams a register file out as valid/ready beats, one word per fetch.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int BitWidth = 32,
  parameter int RegCount = 32,
  localparam int AW = get_min_width(RegCount)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [AW-1:0]       rAddr,
  input  logic [BitWidth-1:0] rData,
  output logic [BitWidth-1:0] outData,
  output logic [AW-1:0]       outAddr,
  output logic                outValid,
  input  logic                outReady,
  output logic                outLast,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] LastIdx = AW'(RegCount - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  localparam dump_state_e AfterLast = S_CHECK;
`else
  localparam dump_state_e AfterLast = S_DONE;
`endif

  dump_state_e   state, state_nx;
  logic [AW-1:0] index;
  logic [AW-1:0] raddr_q;
  logic          accept;
  logic          at_last;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [BitWidth-1:0] chk;
`endif

  assign accept  = outValid && outReady;
  assign at_last = (index == LastIdx);
  assign rAddr   = (state == S_FETCH) ? index : raddr_q;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_SEND;
      S_SEND:
        if (accept)
          state_nx = at_last ? AfterLast : S_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
      S_CHECK: if (accept) state_nx = S_DONE;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index    <= '0;
      raddr_q  <= '0;
      outData  <= '0;
      outAddr  <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE:
          if (start) begin
            index <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        S_FETCH: begin
          raddr_q  <= index;
          outData  <= rData;
          outAddr  <= index;
          outValid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          outLast  <= 1'b0;
          chk      <= chk ^ rData;
`else
          outLast  <= at_last;
`endif
        end
        S_SEND:
          if (accept) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
            if (!at_last) begin
              index <= index + 1'b1;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // checksum beat follows the last register directly
              outData  <= chk;
              outAddr  <= '0;
              outValid <= 1'b1;
              outLast  <= 1'b1;
`endif
            end
          end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CHECK:
          if (accept) begin
            outValid <= 1'b0;
            outLast  <= 1'b0;
          end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: queue-based beat model plus directed cases.
// Honours REG_DUMP_CHECKSUM_EN when defined for the build.
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif
  localparam int Beats = 32 + int'(ChkEn);

  logic        clk = 1'b0;
  logic        reset, start, outReady;
  logic [4:0]  rAddr, outAddr;
  logic [31:0] rData, outData;
  logic        outValid, outLast, busy, done;

  logic        start2, ready2;
  logic [0:0]  rAddr2, outAddr2;
  logic [31:0] rData2, outData2;
  logic        valid2, last2, busy2, done2;

  logic [31:0] regs [32];
  logic [31:0] regs2 [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rData  = regs[rAddr];
  assign rData2 = regs2[rAddr2];

  reg_dump dut (
    .clock(clk), .reset(reset), .start(start),
    .rAddr(rAddr), .rData(rData),
    .outData(outData), .outAddr(outAddr),
    .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .busy(busy), .done(done)
  );

  reg_dump #(.BitWidth(32), .RegCount(2)) dut2 (
    .clock(clk), .reset(reset), .start(start2),
    .rAddr(rAddr2), .rData(rData2),
    .outData(outData2), .outAddr(outAddr2),
    .outValid(valid2), .outReady(ready2),
    .outLast(last2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    beats;
  int    dones;
  int    cyc;
  int    last_acc_cyc;
  logic  prev_hold, prev_done;
  logic [38:0] held;
  logic        beat31_last;
  beat_t       final_beat;

  task automatic push_dump();
    logic [31:0] x;
    x = '0;
    beats = 0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{addr: 5'(i), data: regs[i],
                        last: (i == 31) && !ChkEn});
      x ^= regs[i];
    end
    if (ChkEn) exp_q.push_back('{addr: 5'd0, data: x, last: 1'b1});
  endtask

  initial begin
    cyc = 0; beats = 0; dones = 0; last_acc_cyc = -10;
    prev_hold = 1'b0; prev_done = 1'b0; held = '0;
    beat31_last = 1'b0;
    final_beat = '{addr: '0, data: '0, last: 1'b0};
  end

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_hold)
        chk("hold", {outValid, outLast, outAddr, outData}, held);
      if (outValid) chk("busy_when_valid", 32'(busy), 32'd1);
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(outAddr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 32'(outAddr), 32'(e.addr));
          chk("beat_data", outData, e.data);
          chk("beat_last", 32'(outLast), 32'(e.last));
        end
        if (beats == 31) beat31_last = outLast;
        final_beat = '{addr: outAddr, data: outData, last: outLast};
        beats++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        chk("done_single", 32'(prev_done), 32'd0);
        chk("done_all_beats", 32'(exp_q.size()), 32'd0);
        chk("done_latency", 32'(cyc - last_acc_cyc), 32'd1);
        dones++;
      end
      if (start && !busy) push_dump();
      prev_hold = outValid && !outReady;
      held = {outValid, outLast, outAddr, outData};
      prev_done = done;
    end
    cyc++;
  end

  // small instance recorder
  logic [31:0] b2_data [4];
  logic [0:0]  b2_addr [4];
  logic        b2_last [4];
  int n2 = 0, acc2_cyc = 0, done2_cyc = 0, done2_cnt = 0;

  always @(negedge clk) begin
    if (valid2 && ready2 && n2 < 4) begin
      b2_data[n2] = outData2;
      b2_addr[n2] = outAddr2;
      b2_last[n2] = last2;
      n2++;
      acc2_cyc = cyc;
    end
    if (done2) begin
      done2_cyc = cyc;
      done2_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    if (!done) chk(name, 32'd0, 32'd1);
    step();
    chk({name, "_pulse_end"}, 32'(done), 32'd0);
  endtask

  task automatic wait_beat(input int a);
    int n;
    n = 0;
    while (!(outValid && outAddr == 5'(a)) && n < 200) begin
      step();
      n++;
    end
    chk("reach_beat", 32'(outAddr), 32'(a));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; outReady = 1'b1;
    start2 = 1'b0; ready2 = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
    regs2[0] = 32'h0A0;
    regs2[1] = 32'h0A1;
    step(); step();

    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(outLast), 32'd0);
    chk("rst_raddr", 32'(rAddr), 32'd0);
    chk("rst_oaddr", 32'(outAddr), 32'd0);
    chk("rst_odata", outData, 32'd0);
    reset = 1'b0;
    step();

    // full dump, with a stray start while busy
    pulse_start();
    step(); step(); step();
    chk("busy_running", 32'(busy), 32'd1);
    pulse_start();
    wait_done("dump_a");
    chk("dump_a_beats", 32'(beats), 32'(Beats));
    chk("dump_a_dones", 32'(dones), 32'd1);
    chk("dump_a_b31_last", 32'(beat31_last), 32'(!ChkEn));
    chk("idle_after", 32'(busy), 32'd0);

    // back-pressure on beat 3
    pulse_start();
    wait_beat(3);
    outReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_data", outData, 32'h103);
      chk("stall_addr", 32'(outAddr), 32'd3);
      chk("stall_valid", 32'(outValid), 32'd1);
    end
    outReady = 1'b1;
    wait_done("dump_b");
    chk("dump_b_beats", 32'(beats), 32'(Beats));

    // reset while beat 10 is pending
    pulse_start();
    wait_beat(10);
    outReady = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    outReady = 1'b1;
    step(); step();
    chk("no_partial_done", 32'(dones), 32'd2);
    pulse_start();
    wait_done("dump_c");
    chk("dump_c_beats", 32'(beats), 32'(Beats));
    chk("dump_c_dones", 32'(dones), 32'd3);

    // sparse contents: checksum equals the single non-zero word
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[5] = 32'hDEAD_BEEF;
    pulse_start();
    wait_done("dump_d");
    chk("dump_d_b31_last", 32'(beat31_last), 32'(!ChkEn));
    chk("dump_d_final_data", final_beat.data,
        ChkEn ? 32'hDEAD_BEEF : 32'd0);
    chk("dump_d_final_addr", 32'(final_beat.addr),
        ChkEn ? 32'd0 : 32'd31);
    chk("dump_d_final_last", 32'(final_beat.last), 32'd1);

    // two-register instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int n = 0; n < 40 && done2_cnt == 0; n++) step();
    step();
    chk("rc2_beats", 32'(n2), 32'd2 + 32'(ChkEn));
    chk("rc2_addr0", 32'(b2_addr[0]), 32'd0);
    chk("rc2_addr1", 32'(b2_addr[1]), 32'd1);
    chk("rc2_data0", b2_data[0], 32'h0A0);
    chk("rc2_data1", b2_data[1], 32'h0A1);
    chk("rc2_last0", 32'(b2_last[0]), 32'd0);
    chk("rc2_last1", 32'(b2_last[1]), 32'(!ChkEn));
    chk("rc2_done_cnt", 32'(done2_cnt), 32'd1);
    chk("rc2_done_lat", 32'(done2_cyc - acc2_cyc), 32'd1);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
